// File: rtl/oc8051_cxrom_pkg.sv
// Shared definitions for the oc8051 code-ROM arbiter.
// Holds the default ROM geometry, the burst FSM state encoding and the
// per-cycle grant encoding used by the arbiter and its sub-blocks.
package oc8051_cxrom_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        G_NONE = 2'd0,
        G_CPU  = 2'd1,
        G_AUX  = 2'd2
    } grant_e;

endpackage

// File: rtl/oc8051_cxrom_starve_ctr.sv
// Saturating starvation counter for the auxiliary ROM reader.
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-low reset
//   inc     count one more denied cycle (saturates at MAX)
//   clr     clear the count (takes priority over inc)
//   at_max  count has reached MAX; the next slot must go to aux
module oc8051_cxrom_starve_ctr #(
    parameter int unsigned MAX = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic at_max
);

    localparam logic [3:0] MAX_C = 4'(MAX);

    logic [3:0] count;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values of its inputs, independent of block order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= 4'd0;
        end else if (clr) begin
            count <= 4'd0;
        end else if (inc && (count != MAX_C)) begin
            count <= count + 4'd1;
        end
    end

    assign at_max = (count == MAX_C);

endmodule

// File: rtl/oc8051_cxrom_arb.sv
// Arbiter sharing the single combinational code ROM between the oc8051 fetch
// port and an auxiliary burst reader (secure-boot hash engine). The CPU wins
// every cycle unless aux has been denied STARVE_MAX cycles in a row.
// Ports:
//   clk, rst             clock, asynchronous active-low reset
//   cpu_req/cpu_addr     CPU fetch request and byte address
//   cpu_ack/cpu_data     registered ROM word, valid the cycle after grant
//   aux_start/addr/len   burst start pulse, start address, length in words
//   aux_busy             burst in progress (BURST or FLUSH)
//   aux_valid/aux_data   registered ROM word for the burst reader
//   aux_done             one-cycle pulse marking burst completion
//   rom_addr/rom_data    combinational ROM interface
module oc8051_cxrom_arb
    import oc8051_cxrom_pkg::*;
#(
    parameter int          ADDR_W     = ADDR_W_DEF,
    parameter int          DATA_W     = DATA_W_DEF,
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_data,
    input  logic              aux_start,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [7:0]        aux_len,
    output logic              aux_busy,
    output logic              aux_valid,
    output logic [DATA_W-1:0] aux_data,
    output logic              aux_done,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data
);

    state_e            state;
    grant_e            grant;
    logic [ADDR_W-1:0] aux_ptr;
    logic [7:0]        words_left;
    logic              aux_pend;
    logic              at_max;
    logic              accept;

    assign aux_pend = (state == BURST);
    assign aux_busy = (state != IDLE);
    // A start is only honoured from IDLE; pulses during a burst are dropped.
    assign accept   = (state == IDLE) && aux_start;

    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = G_NONE;
        if (cpu_req && !(aux_pend && at_max)) begin
            grant = G_CPU;
        end else if (aux_pend) begin
            grant = G_AUX;
        end
    end

    // With no grant the CPU address is still presented; the read is discarded.
    assign rom_addr = (grant == G_AUX) ? aux_ptr : cpu_addr;

    oc8051_cxrom_starve_ctr #(
        .MAX (STARVE_MAX)
    ) u_starve (
        .clk    (clk),
        .rst    (rst),
        .inc    (aux_pend && (grant == G_CPU)),
        .clr    ((grant == G_AUX) || !aux_pend),
        .at_max (at_max)
    );

    // Burst FSM and address/length tracking.
    // NOTE: all flops here, including the data holding registers, are reset
    // because the outputs must read zero while reset is asserted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            aux_ptr    <= '0;
            words_left <= 8'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (aux_start) begin
                        aux_ptr    <= aux_addr;
                        words_left <= aux_len;
                        state      <= (aux_len != 8'd0) ? BURST : FLUSH;
                    end
                end
                BURST: begin
                    if (grant == G_AUX) begin
                        aux_ptr    <= aux_ptr + ADDR_W'(WORD_BYTES);
                        words_left <= words_left - 8'd1;
                        if (words_left == 8'd1) begin
                            state <= FLUSH;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Read-data pipeline: one cycle from grant to ack/valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cpu_ack   <= 1'b0;
            cpu_data  <= '0;
            aux_valid <= 1'b0;
            aux_data  <= '0;
            aux_done  <= 1'b0;
        end else begin
            cpu_ack   <= (grant == G_CPU);
            aux_valid <= (grant == G_AUX);
            if (grant == G_CPU) begin
                cpu_data <= rom_data;
            end
            if (grant == G_AUX) begin
                aux_data <= rom_data;
            end
            // Done rides with the final word, or follows an empty-burst accept.
            aux_done <= ((grant == G_AUX) && (words_left == 8'd1))
                     || (accept && (aux_len == 8'd0));
        end
    end

endmodule

// File: tb/tb_oc8051_cxrom_arb.sv
// Directed self-checking bench for oc8051_cxrom_arb. The ROM is modelled as
// word(A) = {A, ~A}; all expected values are hand-computed constants.
module tb_oc8051_cxrom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        cpu_req;
    logic [15:0] cpu_addr;
    logic        cpu_ack;
    logic [31:0] cpu_data;
    logic        aux_start;
    logic [15:0] aux_addr;
    logic [7:0]  aux_len;
    logic        aux_busy;
    logic        aux_valid;
    logic [31:0] aux_data;
    logic        aux_done;
    logic [15:0] rom_addr;
    logic [31:0] rom_data;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    assign rom_data = {rom_addr, ~rom_addr};

    oc8051_cxrom_arb dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_addr),
        .cpu_ack   (cpu_ack),
        .cpu_data  (cpu_data),
        .aux_start (aux_start),
        .aux_addr  (aux_addr),
        .aux_len   (aux_len),
        .aux_busy  (aux_busy),
        .aux_valid (aux_valid),
        .aux_data  (aux_data),
        .aux_done  (aux_done),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Advance one edge and settle 1 ns after it; inputs and samples both
    // happen here, well away from the active edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, ".cpu_ack"},   {31'd0, cpu_ack},   32'd0);
        check({tag, ".cpu_data"},  cpu_data,           32'd0);
        check({tag, ".aux_valid"}, {31'd0, aux_valid}, 32'd0);
        check({tag, ".aux_data"},  aux_data,           32'd0);
        check({tag, ".aux_done"},  {31'd0, aux_done},  32'd0);
        check({tag, ".aux_busy"},  {31'd0, aux_busy},  32'd0);
    endtask

    task automatic start_burst(input logic [15:0] addr, input logic [7:0] len);
        aux_start = 1'b1;
        aux_addr  = addr;
        aux_len   = len;
        tick();
        aux_start = 1'b0;
    endtask

    initial begin
        int k;
        int nvalid;
        logic exp_aux;

        rst       = 1'b0;
        cpu_req   = 1'b0;
        cpu_addr  = 16'h0000;
        aux_start = 1'b0;
        aux_addr  = 16'h0000;
        aux_len   = 8'd0;

        // Reset state
        tick();
        tick();
        check_all_zero("reset");
        rst = 1'b1;
        tick();

        // CPU only
        cpu_req  = 1'b1;
        cpu_addr = 16'h0010;
        #1;
        check("cpu.rom_addr", {16'd0, rom_addr}, 32'h0000_0010);
        tick();
        check("cpu.ack",  {31'd0, cpu_ack},   32'd1);
        check("cpu.data", cpu_data,           32'h0010_FFEF);
        check("cpu.aux_valid", {31'd0, aux_valid}, 32'd0);
        check("cpu.aux_busy",  {31'd0, aux_busy},  32'd0);
        cpu_req = 1'b0;
        tick();
        check("cpu.ack_drop", {31'd0, cpu_ack}, 32'd0);
        check("cpu.data_hold", cpu_data, 32'h0010_FFEF);

        // Aux only, 3 words from 0x0100
        start_burst(16'h0100, 8'd3);
        check("aux.busy", {31'd0, aux_busy}, 32'd1);
        check("aux.rom_addr", {16'd0, rom_addr}, 32'h0000_0100);
        tick();
        check("aux.v0", {31'd0, aux_valid}, 32'd1);
        check("aux.d0", aux_data, 32'h0100_FEFF);
        check("aux.done0", {31'd0, aux_done}, 32'd0);
        tick();
        check("aux.v1", {31'd0, aux_valid}, 32'd1);
        check("aux.d1", aux_data, 32'h0104_FEFB);
        tick();
        check("aux.v2", {31'd0, aux_valid}, 32'd1);
        check("aux.d2", aux_data, 32'h0108_FEF7);
        check("aux.done2", {31'd0, aux_done}, 32'd1);
        check("aux.busy2", {31'd0, aux_busy}, 32'd1);
        tick();
        check("aux.v_end", {31'd0, aux_valid}, 32'd0);
        check("aux.done_end", {31'd0, aux_done}, 32'd0);
        check("aux.busy_end", {31'd0, aux_busy}, 32'd0);

        // Contention: CPU requests continuously, burst of 2 from 0x0200.
        // Aux wins after 4 denied cycles: grants land in observations 6 and 11.
        cpu_req  = 1'b1;
        cpu_addr = 16'h0020;
        start_burst(16'h0200, 8'd2);
        for (k = 1; k <= 12; k++) begin
            if (k > 1) tick();
            exp_aux = (k == 6) || (k == 11);
            check($sformatf("cont.ack%0d", k),   {31'd0, cpu_ack},   {31'd0, ~exp_aux});
            check($sformatf("cont.valid%0d", k), {31'd0, aux_valid}, {31'd0, exp_aux});
            check($sformatf("cont.done%0d", k),  {31'd0, aux_done},  {31'd0, k == 11});
            if (k == 6)  check("cont.d0", aux_data, 32'h0200_FDFF);
            if (k == 11) check("cont.d1", aux_data, 32'h0204_FDFB);
        end
        check("cont.cpu_data", cpu_data, 32'h0020_FFDF);
        check("cont.busy_end", {31'd0, aux_busy}, 32'd0);
        cpu_req = 1'b0;
        tick();

        // Address wrap at the top of the ROM
        start_burst(16'hFFFC, 8'd2);
        tick();
        check("wrap.v0", {31'd0, aux_valid}, 32'd1);
        check("wrap.d0", aux_data, 32'hFFFC_0003);
        tick();
        check("wrap.v1", {31'd0, aux_valid}, 32'd1);
        check("wrap.d1", aux_data, 32'h0000_FFFF);
        check("wrap.done", {31'd0, aux_done}, 32'd1);
        tick();
        check("wrap.busy_end", {31'd0, aux_busy}, 32'd0);

        // Empty burst
        start_burst(16'h0700, 8'd0);
        check("empty.done", {31'd0, aux_done}, 32'd1);
        check("empty.valid", {31'd0, aux_valid}, 32'd0);
        check("empty.busy", {31'd0, aux_busy}, 32'd1);
        tick();
        check("empty.done_end", {31'd0, aux_done}, 32'd0);
        check("empty.busy_end", {31'd0, aux_busy}, 32'd0);

        // Start while busy is ignored: still exactly 2 words from 0x0300
        start_burst(16'h0300, 8'd2);
        aux_start = 1'b1;
        aux_addr  = 16'h0400;
        aux_len   = 8'd5;
        tick();
        aux_start = 1'b0;
        check("busy.v0", {31'd0, aux_valid}, 32'd1);
        check("busy.d0", aux_data, 32'h0300_FCFF);
        tick();
        check("busy.d1", aux_data, 32'h0304_FCFB);
        check("busy.done", {31'd0, aux_done}, 32'd1);
        nvalid = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (aux_valid) nvalid++;
        end
        check("busy.extra_valid", nvalid, 32'd0);
        check("busy.idle", {31'd0, aux_busy}, 32'd0);

        // Reset mid-burst after the first of 4 words
        cpu_req  = 1'b1;
        cpu_addr = 16'h0030;
        tick();
        cpu_req  = 1'b0;
        start_burst(16'h0500, 8'd4);
        tick();
        check("rst.v0", {31'd0, aux_valid}, 32'd1);
        check("rst.d0", aux_data, 32'h0500_FAFF);
        #2;
        rst = 1'b0;
        #1;
        check_all_zero("rst.async");
        for (int i = 0; i < 3; i++) begin
            tick();
            check($sformatf("rst.hold_done%0d", i), {31'd0, aux_done}, 32'd0);
        end
        rst = 1'b1;
        nvalid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (aux_valid || aux_done) nvalid++;
        end
        check("rst.quiet", nvalid, 32'd0);
        check("rst.busy", {31'd0, aux_busy}, 32'd0);
        start_burst(16'h0600, 8'd1);
        tick();
        check("rst.new_v", {31'd0, aux_valid}, 32'd1);
        check("rst.new_d", aux_data, 32'h0600_F9FF);
        check("rst.new_done", {31'd0, aux_done}, 32'd1);
        tick();
        check("rst.new_idle", {31'd0, aux_busy}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
